// File: rtl/alu_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO result registers and start/busy/done handshake.
// Optional ALU_MULDIV_EARLY_OUT_EN: multiply leaves CALC as soon as the remaining multiplier is zero.
//
// state | meaning
// IDLE  | waiting for start; result registers hold
// CALC  | one shift-add / restoring-divide iteration per cycle
// FIX   | sign correction, HI/LO write, done pulse
module alu_muldiv #(
  parameter int NBITS = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       muldiv_op,
  input  logic [NBITS-1:0] operando_A,
  input  logic [NBITS-1:0] operando_B,
  output logic             busy,
  output logic             done,
  output logic [NBITS-1:0] hi,
  output logic [NBITS-1:0] lo,
  output logic             div_zero
);

  localparam int CW = $clog2(NBITS);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               dz_q, dz_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic [2*NBITS-1:0] acc_q, acc_d;
  logic [2*NBITS-1:0] b_q, b_d;
  logic [NBITS-1:0]   m_q, m_d;
  logic [NBITS-1:0]   hi_q, hi_d;
  logic [NBITS-1:0]   lo_q, lo_d;
  logic               div_zero_q, div_zero_d;
  logic               done_q, done_d;

  logic               a_neg, b_neg, b_is_zero;
  logic [NBITS-1:0]   mag_a, mag_b;
  logic [NBITS:0]     trial, diff;
  logic [2*NBITS-1:0] prod;
  logic [NBITS-1:0]   quo, rem;
  logic               early;

  assign a_neg     = muldiv_op[0] & operando_A[NBITS-1];
  assign b_neg     = muldiv_op[0] & operando_B[NBITS-1];
  assign mag_a     = a_neg ? -operando_A : operando_A;
  assign mag_b     = b_neg ? -operando_B : operando_B;
  assign b_is_zero = (operando_B == '0);

  // Restoring step: partial remainder sits in the upper half, dividend bits shift out of the lower half.
  assign trial = acc_q[2*NBITS-1:NBITS-1];
  assign diff  = trial - {1'b0, b_q[NBITS-1:0]};

  assign prod = neg_res_q ? -acc_q : acc_q;
  assign quo  = neg_res_q ? -acc_q[NBITS-1:0] : acc_q[NBITS-1:0];
  assign rem  = neg_rem_q ? -acc_q[2*NBITS-1:NBITS] : acc_q[2*NBITS-1:NBITS];

`ifdef ALU_MULDIV_EARLY_OUT_EN
  assign early = !is_div_q && (m_q[NBITS-1:1] == '0);
`else
  assign early = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_div_d   = is_div_q;
    dz_d       = dz_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    acc_d      = acc_q;
    b_d        = b_q;
    m_d        = m_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    div_zero_d = div_zero_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = CALC;
          is_div_d  = muldiv_op[1];
          dz_d      = muldiv_op[1] & b_is_zero;
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          // A zero divisor spends a single inert CALC cycle, giving a two-edge latency.
          cnt_d     = (muldiv_op[1] & b_is_zero) ? '0 : CW'(NBITS-1);
          if (muldiv_op[1]) begin
            acc_d = {{NBITS{1'b0}}, (b_is_zero ? operando_A : mag_a)};
            b_d   = {{NBITS{1'b0}}, mag_b};
            m_d   = '0;
          end else begin
            acc_d = '0;
            b_d   = {{NBITS{1'b0}}, mag_a};
            m_d   = mag_b;
          end
        end
      end
      CALC: begin
        if (!dz_q) begin
          if (is_div_q) begin
            if (!diff[NBITS]) acc_d = {diff[NBITS-1:0], acc_q[NBITS-2:0], 1'b1};
            else              acc_d = {acc_q[2*NBITS-2:0], 1'b0};
          end else begin
            if (m_q[0]) acc_d = acc_q + b_q;
            b_d = b_q << 1;
            m_d = m_q >> 1;
          end
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0 || early) state_d = FIX;
      end
      FIX: begin
        if (dz_q) begin
          lo_d = '1;
          hi_d = acc_q[NBITS-1:0];
        end else if (is_div_q) begin
          lo_d = quo;
          hi_d = rem;
        end else begin
          lo_d = prod[NBITS-1:0];
          hi_d = prod[2*NBITS-1:NBITS];
        end
        div_zero_d = dz_q;
        done_d     = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      dz_q       <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      acc_q      <= '0;
      b_q        <= '0;
      m_q        <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      div_zero_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_div_q   <= is_div_d;
      dz_q       <= dz_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      acc_q      <= acc_d;
      b_q        <= b_d;
      m_q        <= m_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      div_zero_q <= div_zero_d;
      done_q     <= done_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = div_zero_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed scoreboard bench for alu_muldiv (NBITS=32); honours ALU_MULDIV_EARLY_OUT_EN in its latency model.
module tb_alu_muldiv;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  muldiv_op = 2'b00;
  logic [31:0] operando_A = '0;
  logic [31:0] operando_B = '0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  alu_muldiv #(.NBITS(32)) dut (
    .clk(clk), .reset(reset), .start(start), .muldiv_op(muldiv_op),
    .operando_A(operando_A), .operando_B(operando_B),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   nchk = 0;
  int   nerr = 0;
  int   acc_cyc = 0;
  int   done_seen = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    nchk++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic signed [63:0] sa, sb64;
    logic signed [31:0] sa32, sb32;
    logic [63:0] p;
    logic [31:0] mb;
    int k;
    e.dz = 1'b0;
    e.lat = 33;
    mb = b;
    if (!op[1]) begin
      if (op[0]) begin
        sa = $signed(a);
        sb64 = $signed(b);
        p = sa * sb64;
        mb = b[31] ? -b : b;
      end else begin
        p = {32'b0, a} * {32'b0, b};
      end
      e.hi = p[63:32];
      e.lo = p[31:0];
`ifdef ALU_MULDIV_EARLY_OUT_EN
      k = 0;
      for (int i = 0; i < 32; i++) if (mb[i]) k = i;
      e.lat = k + 2;
`else
      k = 0;
`endif
    end else if (b == 32'd0) begin
      e.lo = 32'hFFFF_FFFF;
      e.hi = a;
      e.dz = 1'b1;
      e.lat = 2;
    end else if (!op[0]) begin
      e.lo = a / b;
      e.hi = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.lo = 32'h8000_0000;
      e.hi = 32'h0;
    end else begin
      sa32 = a;
      sb32 = b;
      e.lo = sa32 / sb32;
      e.hi = sa32 % sb32;
    end
    return e;
  endfunction

  // Drives one start cycle, then scrambles the operands to prove they were latched.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    sb.push_back(model(op, a, b));
    muldiv_op = op;
    operando_A = a;
    operando_B = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    start = 1'b0;
    muldiv_op = 2'($urandom);
    operando_A = $urandom;
    operando_B = $urandom;
    chk("busy_after_accept", 64'(busy), 64'(1));
  endtask

  task automatic wait_check(input string tag);
    exp_t e;
    int guard;
    e = sb.pop_front();
    guard = 0;
    while (1) begin
      @(posedge clk);
      #1;
      guard++;
      if (done === 1'b1 || guard > 100) break;
    end
    chk({tag, "_done"}, 64'(done), 64'(1));
    chk({tag, "_lat"}, 64'(cyc - acc_cyc), 64'(e.lat));
    chk({tag, "_hi"}, 64'(hi), 64'(e.hi));
    chk({tag, "_lo"}, 64'(lo), 64'(e.lo));
    chk({tag, "_dz"}, 64'(div_zero), 64'(e.dz));
    chk({tag, "_busy_at_done"}, 64'(busy), 64'(0));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_hi", 64'(hi), 64'(0));
    chk("rst_lo", 64'(lo), 64'(0));
    chk("rst_dz", 64'(div_zero), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    issue(2'b00, 32'hFFFF_FFFF, 32'd2);         wait_check("multu_max_x2");
    @(negedge clk);
    issue(2'b01, 32'hFFFF_FFFD, 32'd5);         wait_check("mult_neg3_x5");
    @(negedge clk);
    issue(2'b10, 32'd7, 32'd2);                 wait_check("divu_7_2");
    @(negedge clk);
    issue(2'b11, 32'hFFFF_FFF9, 32'd2);         wait_check("div_neg7_2");
    @(negedge clk);
    issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF); wait_check("div_min_m1");
    @(negedge clk);
    issue(2'b11, 32'h0000_1234, 32'd0);         wait_check("div_by_zero");
    @(negedge clk);
    issue(2'b00, 32'd2, 32'd3);
    chk("dz_held_while_busy", 64'(div_zero), 64'(1));
    wait_check("multu_clears_dz");

    for (int i = 0; i < 8; i++) begin
      logic [1:0] op;
      logic [31:0] a, b;
      op = 2'(i % 4);
      a = $urandom;
      b = (i == 5) ? 32'd0 : $urandom >> (i * 3);
      @(negedge clk);
      issue(op, a, b);
      wait_check($sformatf("rand%0d", i));
    end

    // start during busy must be ignored
    @(negedge clk);
    issue(2'b01, 32'd1000, 32'hFFFF_FFF0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    muldiv_op = 2'b10;
    operando_A = 32'd99;
    operando_B = 32'd4;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_check("ignored_start");
    @(posedge clk);
    #1;
    chk("no_queued_op_busy", 64'(busy), 64'(0));

    // back-to-back: start in the done cycle
    @(negedge clk);
    issue(2'b10, 32'd1000, 32'd7);
    wait_check("b2b_first");
    issue(2'b00, 32'd12345, 32'd678);
    wait_check("b2b_second");

    // reset mid-DIV aborts without done
    @(negedge clk);
    issue(2'b11, 32'hDEAD_BEEF, 32'd3);
    void'(sb.pop_back());
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_hi", 64'(hi), 64'(0));
    chk("abort_lo", 64'(lo), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    done_seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) done_seen++;
    end
    chk("abort_no_done", 64'(done_seen), 64'(0));

    @(negedge clk);
    issue(2'b00, 32'd5, 32'd1);
    wait_check("multu_5x1");

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
